// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
// Shared types for the SPI transaction arbiter: the controller state encoding
// and the response status codes returned alongside rsp_valid.
// ---------------------------------------------------------------------------
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT = 2'b01;
  localparam logic [1:0] RSP_BADLEN  = 2'b10;

endpackage : spi_arb_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first set request
// bit found searching upward from ptr_i, wrapping modulo NUM_REQ.
//
// Ports
//   req_i        request vector
//   ptr_i        index where the search starts (highest priority this cycle)
//   grant_o      one-hot winner (all zero when nothing is requested)
//   grant_idx_o  binary index of the winner (0 when nothing is requested)
//   any_req_o    at least one request bit is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       any_req_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_i) + i) % NUM_REQ;
      if (!any_req_o && req_i[idx]) begin
        any_req_o    = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/spi_transaction_arbiter.sv
// ---------------------------------------------------------------------------
// spi_transaction_arbiter
// Shares one half-duplex SPI master between NUM_REQ fabric requesters. One
// transaction at a time is accepted round-robin, launched as a single-cycle
// length pulse, and completed either by the master's m_done strobe or by a
// programmable timeout. Read data and status return to the winner.
//
// Ports
//   fabric_clk, reset_n       clock; synchronous active-low reset
//   req_valid / req_ready     per-requester request and one-hot accept
//   req_length/data/rw_mask   packed per-requester transaction fields
//   rsp_valid                 one-cycle response strobe to the winner
//   rsp_data / rsp_error      captured read data and status (00/01/10)
//   timeout_cycles            WAIT limit in cycles, 0 disables
//   m_transaction_*           command to the SPI master
//   m_transaction_read_data   read data from the SPI master
//   m_done                    completion strobe from the SPI master
//   busy                      controller is not IDLE
//   grant_id                  current or last winner
// ---------------------------------------------------------------------------
module spi_transaction_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ               = 4,
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned TRANSACTION_LEN_WIDTH = 6,
  parameter int unsigned TIMEOUT_WIDTH         = 16
) (
  input  logic                                   fabric_clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_rw_mask,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [DATA_WIDTH-1:0]                  rsp_data,
  output logic [1:0]                             rsp_error,
  input  logic [TIMEOUT_WIDTH-1:0]               timeout_cycles,
  output logic [TRANSACTION_LEN_WIDTH-1:0]       m_transaction_length,
  output logic [DATA_WIDTH-1:0]                  m_transaction_data,
  output logic [DATA_WIDTH-1:0]                  m_transaction_rw_mask,
  input  logic [DATA_WIDTH-1:0]                  m_transaction_read_data,
  input  logic                                   m_done,
  output logic                                   busy,
  output logic [$clog2(NUM_REQ)-1:0]             grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned LEN_W = TRANSACTION_LEN_WIDTH;

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [DATA_WIDTH-1:0]    mask_q, mask_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]               err_q, err_d;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  logic [NUM_REQ-1:0]       win_oh;
  logic [IDX_W-1:0]         win_idx;
  logic                     any_req;
  logic [LEN_W-1:0]         win_len;
  logic [DATA_WIDTH-1:0]    win_data;
  logic [DATA_WIDTH-1:0]    win_mask;
  logic                     win_badlen;
  logic                     timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (win_oh),
    .grant_idx_o (win_idx),
    .any_req_o   (any_req)
  );

  assign win_len  = req_length[32'(win_idx)*LEN_W +: LEN_W];
  assign win_data = req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_mask = req_rw_mask[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Lengths the master cannot shift are rejected without touching the bus.
  assign win_badlen = (win_len == '0) || (32'(win_len) > DATA_WIDTH);

  // The counter reads 0 in the first WAIT cycle, so WAIT lasts exactly
  // timeout_cycles cycles before giving up.
  assign timeout_hit = (timeout_cycles != '0) &&
                       (wait_cnt_q == timeout_cycles - TIMEOUT_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    len_d      = len_q;
    data_d     = data_q;
    mask_d     = mask_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    req_ready            = '0;
    rsp_valid            = '0;
    m_transaction_length = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = win_oh;
          grant_d   = win_idx;
          len_d     = win_len;
          data_d    = win_data;
          mask_d    = win_mask;
          if (win_badlen) begin
            err_d   = RSP_BADLEN;
            state_d = RESPOND;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        m_transaction_length = len_q;
        wait_cnt_d           = '0;
        state_d              = WAIT;
      end

      WAIT: begin
        if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
        end
        // Completion takes priority over a timeout landing in the same cycle.
        if (m_done) begin
          rsp_data_d = m_transaction_read_data;
          err_d      = RSP_OK;
          state_d    = RESPOND;
        end else if (timeout_hit) begin
          err_d   = RSP_TIMEOUT;
          state_d = RESPOND;
        end
      end

      RESPOND: begin
        rsp_valid = NUM_REQ'(1) << grant_q;
        rr_ptr_d  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and sample reset_n on
  // the clock edge only; reset is synchronous, so it is not in the sensitivity
  // list.
  always_ff @(posedge fabric_clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      len_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      rsp_data_q <= '0;
      err_q      <= RSP_OK;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      len_q      <= len_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign m_transaction_data    = data_q;
  assign m_transaction_rw_mask = mask_q;
  assign rsp_data              = rsp_data_q;
  assign rsp_error             = err_q;
  assign busy                  = (state_q != IDLE);
  assign grant_id              = grant_q;

endmodule : spi_transaction_arbiter

// File: tb/tb_spi_transaction_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_transaction_arbiter
// Directed bench for spi_transaction_arbiter. Inputs change and outputs are
// sampled just after the falling edge, away from the active rising edge.
// Each "cycle" below is the interval between two rising edges; T is the
// cycle in which a request is accepted.
// ---------------------------------------------------------------------------
module tb_spi_transaction_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 6;
  localparam int TW = 16;

  logic              fabric_clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*LW-1:0]   req_length;
  logic [N*DW-1:0]   req_data;
  logic [N*DW-1:0]   req_rw_mask;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [1:0]        rsp_error;
  logic [TW-1:0]     timeout_cycles;
  logic [LW-1:0]     m_len;
  logic [DW-1:0]     m_data;
  logic [DW-1:0]     m_mask;
  logic [DW-1:0]     m_rd;
  logic              m_done;
  logic              busy;
  logic [1:0]        grant_id;

  int total = 0;
  int bad   = 0;

  always #5 fabric_clk = ~fabric_clk;

  spi_transaction_arbiter #(
    .NUM_REQ               (N),
    .DATA_WIDTH            (DW),
    .TRANSACTION_LEN_WIDTH (LW),
    .TIMEOUT_WIDTH         (TW)
  ) dut (
    .fabric_clk              (fabric_clk),
    .reset_n                 (reset_n),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_length              (req_length),
    .req_data                (req_data),
    .req_rw_mask             (req_rw_mask),
    .rsp_valid               (rsp_valid),
    .rsp_data                (rsp_data),
    .rsp_error               (rsp_error),
    .timeout_cycles          (timeout_cycles),
    .m_transaction_length    (m_len),
    .m_transaction_data      (m_data),
    .m_transaction_rw_mask   (m_mask),
    .m_transaction_read_data (m_rd),
    .m_done                  (m_done),
    .busy                    (busy),
    .grant_id                (grant_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [LW-1:0] len,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_length[i*LW +: LW]  = len;
    req_data[i*DW +: DW]    = d;
    req_rw_mask[i*DW +: DW] = m;
  endtask

  task automatic next_cycle();
    @(negedge fabric_clk);
  endtask

  // Leaves the bench at a falling edge with reset_n just released; the
  // following rising edge is the first normal cycle.
  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    m_done    = 1'b0;
    repeat (2) next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = '0;
    req_length     = '0;
    req_data       = '0;
    req_rw_mask    = '0;
    timeout_cycles = '0;
    m_rd           = '0;
    m_done         = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) next_cycle();
    #1;
    check("rst_ready",  req_ready, 4'b0000);
    check("rst_rspv",   rsp_valid, 4'b0000);
    check("rst_rspd",   rsp_data,  32'h0);
    check("rst_err",    rsp_error, 2'b00);
    check("rst_mlen",   m_len,     6'd0);
    check("rst_mdata",  m_data,    32'h0);
    check("rst_mmask",  m_mask,    32'h0);
    check("rst_busy",   busy,      1'b0);
    check("rst_gid",    grant_id,  2'd0);
    reset_n = 1'b1;

    // ---------------- single request on requester 1 ----------------
    next_cycle();                                   // T
    set_req(1, 6'd8, 32'hA500_0000, 32'hFF00_0000);
    req_valid = 4'b0010;
    #1;
    check("s_ready", req_ready, 4'b0010);
    check("s_busy0", busy, 1'b0);
    next_cycle();                                   // T+1: pulse
    req_valid = '0;
    #1;
    check("s_pulse", m_len,    6'd8);
    check("s_data",  m_data,   32'hA500_0000);
    check("s_mask",  m_mask,   32'hFF00_0000);
    check("s_gid",   grant_id, 2'd1);
    check("s_busy1", busy,     1'b1);
    check("s_nordy", req_ready, 4'b0000);
    for (int c = 0; c < 4; c++) begin               // T+2..T+5
      next_cycle();
      #1;
      check("s_len0",  m_len,     6'd0);
      check("s_hold",  m_data,    32'hA500_0000);
      check("s_nrsp",  rsp_valid, 4'b0000);
    end
    next_cycle();                                   // T+6: pulse+5
    m_done = 1'b1;
    m_rd   = 32'h1234_5678;
    #1;
    check("s_nrsp2", rsp_valid, 4'b0000);
    next_cycle();                                   // T+7: RESPOND
    m_done = 1'b0;
    m_rd   = '0;
    #1;
    check("s_rspv",  rsp_valid, 4'b0010);
    check("s_rspd",  rsp_data,  32'h1234_5678);
    check("s_err",   rsp_error, 2'b00);
    next_cycle();
    #1;
    check("s_rspv0", rsp_valid, 4'b0000);
    check("s_idle",  busy,      1'b0);

    // ---------------- round robin, all four requesting ----------------
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, LW'(8 * (i + 1)), 32'h1000_0000 * (i + 1), 32'hFFFF_FFFF);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      logic [N-1:0] oh;
      logic [DW-1:0] rd;
      g  = k % N;
      oh = N'(1) << g;
      rd = 32'hC0DE_0000 | DW'(k);
      #1;
      check("rr_ready", req_ready, oh);             // accept
      next_cycle();
      #1;
      check("rr_gid",  grant_id,  g);               // pulse
      check("rr_len",  m_len,     8 * (g + 1));
      check("rr_nrsp", rsp_valid, 4'b0000);
      next_cycle();                                 // WAIT, done at once
      m_done = 1'b1;
      m_rd   = rd;
      next_cycle();
      m_done = 1'b0;
      #1;
      check("rr_rspv", rsp_valid, oh);
      check("rr_rspd", rsp_data,  rd);
      next_cycle();
    end
    req_valid = '0;

    // ---------------- timeout with no m_done ----------------
    // WAIT occupies the 10 cycles after the pulse; the 10th one expires the
    // counter and the response strobe follows in the next cycle.
    do_reset();
    timeout_cycles = 16'd10;
    set_req(2, 6'd16, 32'hBEEF_0000, 32'hFFFF_0000);
    req_valid = 4'b0100;
    #1;
    check("to_ready", req_ready, 4'b0100);
    next_cycle();
    req_valid = '0;
    #1;
    check("to_pulse", m_len, 6'd16);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      #1;
      check("to_wait", rsp_valid, 4'b0000);
      check("to_busy", busy,      1'b1);
    end
    next_cycle();
    #1;
    check("to_rspv", rsp_valid, 4'b0100);
    check("to_err",  rsp_error, 2'b01);
    check("to_rspd", rsp_data,  32'h0);
    next_cycle();                                   // IDLE, late m_done
    m_done = 1'b1;
    m_rd   = 32'hDEAD_BEEF;
    #1;
    check("to_idle", busy, 1'b0);
    next_cycle();
    m_done = 1'b0;
    #1;
    check("to_late_rspv", rsp_valid, 4'b0000);
    check("to_late_rspd", rsp_data,  32'h0);
    check("to_late_busy", busy,      1'b0);
    check("to_late_len",  m_len,     6'd0);

    // ---------------- bad lengths (rr_ptr now 3) ----------------
    set_req(3, 6'd0, 32'h1, 32'h1);
    req_valid = 4'b1000;
    #1;
    check("bl0_ready", req_ready, 4'b1000);
    check("bl0_len_a", m_len,     6'd0);
    next_cycle();
    req_valid = '0;
    #1;
    check("bl0_rspv",  rsp_valid, 4'b1000);
    check("bl0_err",   rsp_error, 2'b10);
    check("bl0_len_b", m_len,     6'd0);
    next_cycle();
    set_req(0, 6'd33, 32'h2, 32'h2);
    req_valid = 4'b0001;
    #1;
    check("bl33_ready", req_ready, 4'b0001);
    check("bl33_len_a", m_len,     6'd0);
    next_cycle();
    req_valid = '0;
    #1;
    check("bl33_rspv",  rsp_valid, 4'b0001);
    check("bl33_err",   rsp_error, 2'b10);
    check("bl33_len_b", m_len,     6'd0);
    next_cycle();
    #1;
    check("bl_idle",  busy,  1'b0);
    check("bl_len_c", m_len, 6'd0);

    // ---------------- m_done in the final WAIT cycle (rr_ptr now 1) --------
    timeout_cycles = 16'd4;
    set_req(1, 6'd8, 32'h5A00_0000, 32'hFF00_0000);
    req_valid = 4'b0010;
    #1;
    check("sim_ready", req_ready, 4'b0010);
    next_cycle();
    req_valid = '0;
    #1;
    check("sim_pulse", m_len, 6'd8);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      check("sim_wait", rsp_valid, 4'b0000);
    end
    next_cycle();                                   // 4th WAIT cycle
    m_done = 1'b1;
    m_rd   = 32'h0BAD_F00D;
    next_cycle();
    m_done = 1'b0;
    #1;
    check("sim_rspv", rsp_valid, 4'b0010);
    check("sim_err",  rsp_error, 2'b00);
    check("sim_rspd", rsp_data,  32'h0BAD_F00D);
    next_cycle();
    timeout_cycles = '0;

    // ---------------- reset during WAIT (rr_ptr now 2) ----------------
    set_req(2, 6'd12, 32'h7700_0000, 32'hFFF0_0000);
    req_valid = 4'b0100;
    #1;
    check("rw_ready", req_ready, 4'b0100);
    next_cycle();
    req_valid = '0;
    #1;
    check("rw_pulse", m_len, 6'd12);
    next_cycle();
    #1;
    check("rw_inwait", busy, 1'b1);
    reset_n = 1'b0;
    next_cycle();
    #1;
    check("rw_busy",  busy,      1'b0);
    check("rw_gid",   grant_id,  2'd0);
    check("rw_rspd",  rsp_data,  32'h0);
    check("rw_err",   rsp_error, 2'b00);
    check("rw_mdata", m_data,    32'h0);
    check("rw_mmask", m_mask,    32'h0);
    check("rw_mlen",  m_len,     6'd0);
    check("rw_rspv",  rsp_valid, 4'b0000);
    reset_n = 1'b1;
    m_done  = 1'b1;                                  // master finishes late
    m_rd    = 32'hFFFF_FFFF;
    next_cycle();
    m_done = 1'b0;
    #1;
    check("rw_late_rspv", rsp_valid, 4'b0000);
    check("rw_late_rspd", rsp_data,  32'h0);
    set_req(0, 6'd4, 32'h9000_0000, 32'hF000_0000);
    req_valid = 4'b1111;
    #1;
    check("rw_ptr0", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    #1;
    check("rw2_pulse", m_len,  6'd4);
    check("rw2_data",  m_data, 32'h9000_0000);
    next_cycle();
    m_done = 1'b1;
    m_rd   = 32'h0000_CAFE;
    next_cycle();
    m_done = 1'b0;
    #1;
    check("rw2_rspv", rsp_valid, 4'b0001);
    check("rw2_rspd", rsp_data,  32'h0000_CAFE);
    check("rw2_err",  rsp_error, 2'b00);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spi_transaction_arbiter
